// File: rtl/mask_centroid_tracker.sv
// mask_centroid_tracker: per-frame mask count, bounding box and centroid via double-buffered sequential division
module mask_centroid_tracker #(
  parameter int LINES = 640,
  parameter int ROWS = 480,
  parameter int MIN_PIXELS = 64,
  parameter int SUM_W = 29,
  parameter int CNT_W = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_i,
  input  logic             mask_i,
  input  logic [12:0]      row,
  input  logic [12:0]      col,
  output logic [12:0]      cx,
  output logic [12:0]      cy,
  output logic [12:0]      left,
  output logic [12:0]      right,
  output logic [12:0]      top,
  output logic [12:0]      bottom,
  output logic [CNT_W-1:0] pix_count,
  output logic             obj_valid,
  output logic             result_valid,
  output logic             busy,
  output logic             overrun
);
  typedef enum logic [1:0] {ACCUM, DIV, DONE} state_t;
  localparam int IW = $clog2(SUM_W + 1);
  state_t state, state_n;
  logic [CNT_W-1:0] acc_cnt, b_cnt, n_cnt, snap_cnt, remx, remy;
  logic [SUM_W-1:0] acc_sx, acc_sy, b_sx, b_sy, n_sx, n_sy, qx, qy;
  logic [12:0] acc_l, acc_r, acc_t, acc_b, b_l, b_r, b_t, b_b, n_l, n_r, n_t, n_b;
  logic [12:0] snap_l, snap_r, snap_t, snap_b;
  logic [CNT_W:0] rx_s, ry_s;
  logic [IW-1:0] iter;
  logic sof, eof, big, snap_ok, last, gex, gey;
  assign sof  = valid_i && row == 13'd0 && col == 13'd0;
  assign eof  = valid_i && row == 13'(ROWS - 1) && col == 13'(LINES - 1);
  assign big  = n_cnt >= CNT_W'(MIN_PIXELS);
  assign last = iter == IW'(SUM_W - 1);
  assign busy = state == DIV;
  assign rx_s = {remx, qx[SUM_W-1]};
  assign ry_s = {remy, qy[SUM_W-1]};
  assign gex  = rx_s >= {1'b0, snap_cnt};
  assign gey  = ry_s >= {1'b0, snap_cnt};
  // SOF restarts from a clean slate; this pixel's contribution is folded in on top
  always_comb begin
    b_cnt = sof ? '0 : acc_cnt;
    b_sx  = sof ? '0 : acc_sx;
    b_sy  = sof ? '0 : acc_sy;
    b_l   = sof ? 13'h1FFF : acc_l;
    b_r   = sof ? 13'h0 : acc_r;
    b_t   = sof ? 13'h1FFF : acc_t;
    b_b   = sof ? 13'h0 : acc_b;
    n_cnt = b_cnt + CNT_W'(mask_i);
    n_sx  = b_sx + (mask_i ? SUM_W'(col) : '0);
    n_sy  = b_sy + (mask_i ? SUM_W'(row) : '0);
    n_l   = (mask_i && col < b_l) ? col : b_l;
    n_r   = (mask_i && col > b_r) ? col : b_r;
    n_t   = (mask_i && row < b_t) ? row : b_t;
    n_b   = (mask_i && row > b_b) ? row : b_b;
  end
  // control state register
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= ACCUM;
    else state <= state_n;
  // small frames skip the divider; DONE always lasts exactly one cycle
  always_comb begin
    state_n = state;
    state_n = (state == ACCUM && eof) ? (big ? DIV : DONE) :
              (state == DIV && last) ? DONE :
              (state == DONE) ? ACCUM : state;
  end
  // accumulation path, cleared at EOF so the next frame never waits on the divider
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      acc_cnt <= '0;
      acc_sx  <= '0;
      acc_sy  <= '0;
      acc_l   <= 13'h1FFF;
      acc_r   <= '0;
      acc_t   <= 13'h1FFF;
      acc_b   <= '0;
    end else if (valid_i) begin
      acc_cnt <= eof ? '0 : n_cnt;
      acc_sx  <= eof ? '0 : n_sx;
      acc_sy  <= eof ? '0 : n_sy;
      acc_l   <= eof ? 13'h1FFF : n_l;
      acc_r   <= eof ? 13'h0 : n_r;
      acc_t   <= eof ? 13'h1FFF : n_t;
      acc_b   <= eof ? 13'h0 : n_b;
    end
  // snapshot, two restoring dividers sharing the count as divisor, and result load
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      snap_cnt <= '0;
      snap_ok <= 1'b0;
      snap_l <= '0;
      snap_r <= '0;
      snap_t <= '0;
      snap_b <= '0;
      qx <= '0;
      qy <= '0;
      remx <= '0;
      remy <= '0;
      iter <= '0;
      cx <= '0;
      cy <= '0;
      left <= '0;
      right <= '0;
      top <= '0;
      bottom <= '0;
      pix_count <= '0;
      obj_valid <= 1'b0;
      result_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      overrun <= eof && state != ACCUM;
      result_valid <= state == DONE;
      if (eof && state == ACCUM) begin
        snap_cnt <= n_cnt;
        snap_ok <= big;
        snap_l <= n_l;
        snap_r <= n_r;
        snap_t <= n_t;
        snap_b <= n_b;
        qx <= n_sx;
        qy <= n_sy;
        remx <= '0;
        remy <= '0;
        iter <= '0;
      end else if (state == DIV) begin
        qx <= {qx[SUM_W-2:0], gex};
        qy <= {qy[SUM_W-2:0], gey};
        remx <= gex ? CNT_W'(rx_s - {1'b0, snap_cnt}) : rx_s[CNT_W-1:0];
        remy <= gey ? CNT_W'(ry_s - {1'b0, snap_cnt}) : ry_s[CNT_W-1:0];
        iter <= iter + 1'b1;
      end
      if (state == DONE) begin
        pix_count <= snap_cnt;
        obj_valid <= snap_ok;
        if (snap_ok) begin
          cx <= qx[12:0];
          cy <= qy[12:0];
          left <= snap_l;
          right <= snap_r;
          top <= snap_t;
          bottom <= snap_b;
        end
      end
    end
endmodule
